// File: rtl/svm_modulator_dt.sv
// svm_modulator_dt: latches angle/duty, decodes a six-step sector, carrier PWM with per-leg dead time.
// Latency: angle/duty take effect at the next period start; gate outputs are registered (one edge).
// Backpressure: none; shoot=0 or reset forces every gate low on the next edge.
module svm_modulator_dt #(
   parameter int MODULE_ID    = 0,
   parameter int ANGLE_W      = 12,
   parameter int PHASE_OFFSET = 'h555,
   parameter int CNT_W        = 8,
   parameter int PERIOD       = 100,
   parameter int DEAD_CYCLES  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shoot,
   input  logic [ANGLE_W-1:0] angle,
   input  logic [CNT_W-1:0]   duty,
   output logic               g1_a,
   output logic               g2_a,
   output logic               g1_b,
   output logic               g2_b,
   output logic               g1_c,
   output logic               g2_c,
   output logic [2:0]         sector,
   output logic               period_start
);
   // Per-module phase offset, truncated to one electrical turn.
   localparam logic [ANGLE_W-1:0] OFFSET = ANGLE_W'(MODULE_ID * PHASE_OFFSET);
   localparam logic [CNT_W-1:0]   LAST   = CNT_W'(PERIOD - 1);
   localparam logic [3:0]         DEAD   = 4'(DEAD_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   duty_q, duty_d;
   logic [2:0]         sector_q, sector_d, sector_in;
   logic               period_start_q, period_start_d;
   logic               latch;
   logic [ANGLE_W-1:0] angle_eff;
   logic [ANGLE_W+2:0] angle_x6;
   // Leg vectors are ordered {A, B, C}.
   logic [2:0]         vec;
   logic [2:0]         tgt_n, tgt_q, tgt_d;
   logic [2:0]         hi_q, hi_d, lo_q, lo_d;
   logic [3:0]         dead_q [3];
   logic [3:0]         dead_d [3];

   // Sector decode of the incoming angle: floor(angle_eff * 6 / 2^ANGLE_W), always 0..5.
   always_comb begin
      angle_eff = angle + OFFSET;
      angle_x6  = {3'b000, angle_eff} * {{ANGLE_W{1'b0}}, 3'd6};
      sector_in = angle_x6[ANGLE_W+2:ANGLE_W];
   end

   // Carrier FSM: next state, next count and the period-start latch of angle/duty.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      duty_d         = duty_q;
      sector_d       = sector_q;
      period_start_d = 1'b0;
      latch          = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (shoot) begin
               state_d = RUN;
               latch   = 1'b1;
            end
         end
         RUN: begin
            if (!shoot) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               cnt_d = '0;
               latch = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (latch) begin
         duty_d         = duty;
         sector_d       = sector_in;
         period_start_d = 1'b1;
      end
   end

   // Target leg state for the coming cycle: active vector while cnt < duty, zero vector otherwise.
   always_comb begin
      case (sector_d)
         3'd0:    vec = 3'b100;
         3'd1:    vec = 3'b110;
         3'd2:    vec = 3'b010;
         3'd3:    vec = 3'b011;
         3'd4:    vec = 3'b001;
         3'd5:    vec = 3'b101;
         default: vec = 3'b000;
      endcase
      tgt_n = (cnt_d < duty_d) ? vec : 3'b000;
   end

   // Per-leg dead time: any target change (or RUN entry) holds both gates low for DEAD cycles.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         tgt_d[i]  = tgt_q[i];
         dead_d[i] = dead_q[i];
         hi_d[i]   = 1'b0;
         lo_d[i]   = 1'b0;
         if (state_d != RUN) begin
            dead_d[i] = DEAD;
         end else if (state_q != RUN || tgt_n[i] != tgt_q[i]) begin
            tgt_d[i]  = tgt_n[i];
            dead_d[i] = DEAD;
         end else if (dead_q[i] > 4'd1) begin
            dead_d[i] = dead_q[i] - 4'd1;
         end else begin
            dead_d[i] = 4'd0;
            hi_d[i]   = tgt_q[i];
            lo_d[i]   = ~tgt_q[i];
         end
      end
   end

   // State and output registers; reset wins over everything on its edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         duty_q         <= '0;
         sector_q       <= 3'd0;
         period_start_q <= 1'b0;
         tgt_q          <= 3'b000;
         hi_q           <= 3'b000;
         lo_q           <= 3'b000;
         for (int i = 0; i < 3; i++) dead_q[i] <= DEAD;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         duty_q         <= duty_d;
         sector_q       <= sector_d;
         period_start_q <= period_start_d;
         tgt_q          <= tgt_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         for (int i = 0; i < 3; i++) dead_q[i] <= dead_d[i];
      end
   end

   assign g1_a         = hi_q[2];
   assign g2_a         = lo_q[2];
   assign g1_b         = hi_q[1];
   assign g2_b         = lo_q[1];
   assign g1_c         = hi_q[0];
   assign g2_c         = lo_q[0];
   assign sector       = sector_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_svm_modulator_dt.sv
// tb_svm_modulator_dt: scoreboard bench for two svm_modulator_dt instances (MODULE_ID 0 and 1).
// Latency: expected outputs are queued one edge ahead and popped 1ns after each rising edge.
// Backpressure: none; the DUT presents outputs every cycle and the monitor checks every one.
`timescale 1ns/1ps
module tb_svm_modulator_dt;
   localparam int PER = 100;
   localparam int DT  = 4;
   localparam int OFS = 'h555;

   typedef struct packed {
      logic [2:0] g1;
      logic [2:0] g2;
      logic [2:0] sec;
      logic       ps;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, shoot;
   logic [11:0] angle;
   logic [7:0]  duty;
   logic [2:0]  g1_0, g2_0, g1_1, g2_1;
   logic [2:0]  sec0, sec1;
   logic        ps0, ps1;

   int   n_err = 0;
   int   n_chk = 0;
   bit   sweep_mode = 1'b0;
   exp_t q0[$];
   exp_t q1[$];

   // Reference model state: run flag, position in period, latched duty/sector, per-leg change times.
   int       now_c = 0;
   bit       m_run = 1'b0;
   int       m_pos = 0;
   int       m_duty = 0;
   bit       m_ps = 1'b0;
   int       m_sec [2];
   bit [2:0] m_tgt [2];
   int       m_chg [2][3];

   svm_modulator_dt #(.MODULE_ID(0)) dut0 (
      .clk(clk), .reset(reset), .shoot(shoot), .angle(angle), .duty(duty),
      .g1_a(g1_0[2]), .g2_a(g2_0[2]), .g1_b(g1_0[1]), .g2_b(g2_0[1]),
      .g1_c(g1_0[0]), .g2_c(g2_0[0]), .sector(sec0), .period_start(ps0));

   svm_modulator_dt #(.MODULE_ID(1)) dut1 (
      .clk(clk), .reset(reset), .shoot(shoot), .angle(angle), .duty(duty),
      .g1_a(g1_1[2]), .g2_a(g2_1[2]), .g1_b(g1_1[1]), .g2_b(g2_1[1]),
      .g1_c(g1_1[0]), .g2_c(g2_1[0]), .sector(sec1), .period_start(ps1));

   // 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [2:0] active_vec(input int s);
      case (s)
         0:       return 3'b100;
         1:       return 3'b110;
         2:       return 3'b010;
         3:       return 3'b011;
         4:       return 3'b001;
         5:       return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   // One rising edge of the model: predicts both instances' outputs after that edge.
   task automatic model_step(input bit r, input bit s, input int a, input int d);
      bit       enter, do_latch, on;
      logic [2:0] t;
      exp_t     e;
      enter    = 1'b0;
      do_latch = 1'b0;
      now_c++;
      if (r) begin
         m_run = 1'b0; m_pos = 0; m_ps = 1'b0; m_duty = 0;
         m_sec[0] = 0; m_sec[1] = 0;
      end else if (!m_run) begin
         m_ps = 1'b0;
         if (s) begin
            m_run = 1'b1; m_pos = 0; enter = 1'b1; do_latch = 1'b1;
         end
      end else if (!s) begin
         m_run = 1'b0; m_pos = 0; m_ps = 1'b0;
      end else begin
         m_pos    = (m_pos + 1) % PER;
         m_ps     = (m_pos == 0);
         do_latch = m_ps;
      end
      if (do_latch) begin
         m_ps   = 1'b1;
         m_duty = d;
         for (int i = 0; i < 2; i++) m_sec[i] = (((a + i * OFS) % 4096) * 6) / 4096;
      end
      for (int i = 0; i < 2; i++) begin
         t     = (m_run && m_pos < m_duty) ? active_vec(m_sec[i]) : 3'b000;
         e.sec = 3'(m_sec[i]);
         e.ps  = m_ps;
         e.g1  = 3'b000;
         e.g2  = 3'b000;
         for (int l = 0; l < 3; l++) begin
            if (m_run && (enter || t[l] != m_tgt[i][l])) begin
               m_chg[i][l] = now_c;
               m_tgt[i][l] = t[l];
            end
            on      = m_run && (now_c - m_chg[i][l] >= DT);
            e.g1[l] = on & t[l];
            e.g2[l] = on & ~t[l];
         end
         if (i == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Drive one cycle of inputs, record the expectation, advance to the next falling edge.
   task automatic cyc(input bit r, input bit s, input int a, input int d);
      reset = r;
      shoot = s;
      angle = a[11:0];
      duty  = d[7:0];
      model_step(r, s, a & 'hfff, d & 'hff);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per instance after every edge; also checks shoot-through
   // and, during the sweep, handover dead time and sector monotonicity.
   initial begin : monitor
      exp_t e, act;
      int   mon_cyc;
      int   last [3];
      int   run_len [3];
      int   prev_sec;
      int   cur;
      mon_cyc  = 0;
      prev_sec = 0;
      for (int l = 0; l < 3; l++) begin last[l] = 0; run_len[l] = 0; end
      forever begin
         @(posedge clk);
         #1;
         mon_cyc++;
         if (q0.size() > 0) begin
            e   = q0.pop_front();
            act = {g1_0, g2_0, sec0, ps0};
            n_chk++;
            if (act !== e) begin
               n_err++;
               $display("FAIL scoreboard inst0 cyc=%0d: got g1=%b g2=%b sector=%0d ps=%b, expected g1=%b g2=%b sector=%0d ps=%b",
                        mon_cyc, act.g1, act.g2, act.sec, act.ps, e.g1, e.g2, e.sec, e.ps);
            end
         end
         if (q1.size() > 0) begin
            e   = q1.pop_front();
            act = {g1_1, g2_1, sec1, ps1};
            n_chk++;
            if (act !== e) begin
               n_err++;
               $display("FAIL scoreboard inst1 cyc=%0d: got g1=%b g2=%b sector=%0d ps=%b, expected g1=%b g2=%b sector=%0d ps=%b",
                        mon_cyc, act.g1, act.g2, act.sec, act.ps, e.g1, e.g2, e.sec, e.ps);
            end
         end
         n_chk++;
         if (((g1_0 & g2_0) | (g1_1 & g2_1)) != 3'b000) begin
            n_err++;
            $display("FAIL shoot_through cyc=%0d: g1_0=%b g2_0=%b g1_1=%b g2_1=%b, required no leg with both high",
                     mon_cyc, g1_0, g2_0, g1_1, g2_1);
         end
         if (!sweep_mode) begin
            prev_sec = 0;
            for (int l = 0; l < 3; l++) begin last[l] = 0; run_len[l] = 0; end
         end else begin
            for (int l = 0; l < 3; l++) begin
               if (!g1_0[l] && !g2_0[l]) begin
                  run_len[l]++;
               end else begin
                  cur = g1_0[l] ? 1 : 2;
                  if (last[l] != 0 && cur != last[l]) begin
                     n_chk++;
                     if (run_len[l] != DT) begin
                        n_err++;
                        $display("FAIL handover_dead leg=%0d cyc=%0d: got %0d both-low cycles, required %0d",
                                 l, mon_cyc, run_len[l], DT);
                     end
                  end
                  last[l]    = cur;
                  run_len[l] = 0;
               end
            end
            if (ps0) begin
               n_chk++;
               if (int'(sec0) < prev_sec) begin
                  n_err++;
                  $display("FAIL sweep_monotonic cyc=%0d: got sector %0d after %0d", mon_cyc, sec0, prev_sec);
               end
               prev_sec = int'(sec0);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no end of stimulus");
      $fatal(1, "watchdog");
   end

   // Stimulus: directed test-plan sequences, then a long sweep, then random traffic.
   initial begin : stim
      bit s_lvl;
      int a_r, d_r;
      bit r_r;
      cyc(1, 0, 'h999, 60);
      cyc(1, 0, 'h999, 60);
      chk("reset_gates", {26'd0, g1_0, g2_0}, 32'd0);
      chk("reset_sector", {29'd0, sec0}, 32'd0);
      for (int k = 0; k < 200; k++) cyc(0, 0, 'h999, 60);
      chk("safe_off_gates", {20'd0, g1_0, g2_0, g1_1, g2_1}, 32'd0);

      // Six-step decode, sector 3 on module 0, sector 5 on module 1.
      for (int k = 0; k < 300; k++) begin
         cyc(0, 1, 'h999, 60);
         if (k == 3)   chk("six_step_dead_c3", {26'd0, g1_0, g2_0}, 32'd0);
         if (k == 10)  chk("six_step_c10", {26'd0, g1_0, g2_0}, {26'd0, 3'b011, 3'b100});
         if (k == 10)  chk("six_step_sector0", {29'd0, sec0}, 32'd3);
         if (k == 10)  chk("six_step_sector1", {29'd0, sec1}, 32'd5);
         if (k == 61)  chk("six_step_bc_low", {28'd0, g1_0[1], g2_0[1], g1_0[0], g2_0[0]}, 32'd0);
         if (k == 70)  chk("six_step_c70", {26'd0, g1_0, g2_0}, {26'd0, 3'b000, 3'b111});
         if (k == 100) chk("six_step_ps100", {31'd0, ps0}, 32'd1);
         if (k == 150) chk("six_step_ps150", {31'd0, ps0}, 32'd0);
      end
      for (int k = 0; k < 5; k++) cyc(0, 0, 'h999, 60);

      // Duty 0: zero vector only.
      for (int k = 0; k < 250; k++) begin
         cyc(0, 1, 'h999, 0);
         if (k == 150) chk("duty0_gates", {26'd0, g1_0, g2_0}, {26'd0, 3'b000, 3'b111});
      end
      for (int k = 0; k < 5; k++) cyc(0, 0, 'h999, 0);

      // Duty >= PERIOD: permanent active vector; module 1 sits in sector 1.
      for (int k = 0; k < 300; k++) begin
         cyc(0, 1, 0, 200);
         if (k == 150) chk("duty200_inst0", {23'd0, g1_0, g2_0, sec0}, {23'd0, 3'b100, 3'b011, 3'd0});
         if (k == 150) chk("duty200_inst1", {23'd0, g1_1, g2_1, sec1}, {23'd0, 3'b110, 3'b001, 3'd1});
         if (k == 200) chk("duty200_wrap", {26'd0, g1_0, g2_0}, {26'd0, 3'b100, 3'b011});
      end
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 200);

      // Shoot drop at cnt=30.
      for (int k = 0; k <= 30; k++) cyc(0, 1, 'h321, 45);
      cyc(0, 0, 'h321, 45);
      chk("shoot_drop_gates", {20'd0, g1_0, g2_0, g1_1, g2_1}, 32'd0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 'h321, 45);

      // Re-assert: fresh period start and full dead time.
      for (int k = 0; k < 120; k++) begin
         cyc(0, 1, 'h321, 45);
         if (k == 0) chk("reassert_ps", {31'd0, ps0}, 32'd1);
         if (k == 3) chk("reassert_dead", {26'd0, g1_0, g2_0}, 32'd0);
         if (k == 4) chk("reassert_first", {26'd0, g1_0, g2_0}, {26'd0, 3'b110, 3'b001});
      end

      // Reset pulse mid-RUN.
      cyc(1, 1, 'h321, 45);
      chk("reset_mid_gates", {20'd0, g1_0, g2_0, g1_1, g2_1}, 32'd0);
      chk("reset_mid_sector", {29'd0, sec0}, 32'd0);
      for (int k = 0; k < 110; k++) cyc(0, 1, 'h321, 45);

      // Sweep: angle 0..4090 step 10, one period each, random duty held inside 10..90.
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 50);
      sweep_mode = 1'b1;
      for (int k = 0; k < 41000; k++) cyc(0, 1, (k / PER) * 10, int'($urandom_range(10, 90)));
      chk("sweep_final_sector", {29'd0, sec0}, 32'd5);
      sweep_mode = 1'b0;

      // Random traffic: occasional reset, shoot toggles, angle/duty changes at any time.
      s_lvl = 1'b1;
      a_r   = 0;
      d_r   = 50;
      for (int k = 0; k < 4000; k++) begin
         r_r = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 149) == 0) s_lvl = ~s_lvl;
         if ($urandom_range(0, 9) == 0) a_r = int'($urandom_range(0, 4095));
         if ($urandom_range(0, 19) == 0) d_r = int'($urandom_range(0, 255));
         cyc(r_r, s_lvl, a_r, d_r);
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/svm_modulator_dt.md
Name: svm_modulator_dt

Overview:
Parametrised successor of the three-phase gate modulator. It latches a commanded angle and duty, adds a per-module phase offset, and decodes the result into one of six active sectors. It generates carrier-based PWM between the sector's active vector and the zero vector, and inserts dead time on every leg transition. One instance sits per power module between the control/UART path and the gate drivers for legs A/B/C; multiple instances are distinguished by MODULE_ID.

Parameters:
MODULE_ID, 0, index of the power module; selects the phase offset.
ANGLE_W, 12, width of angle input; full turn = 2^ANGLE_W.
PHASE_OFFSET, 12'h555, angle added per MODULE_ID step; the product is truncated to ANGLE_W bits.
CNT_W, 8, width of the carrier counter and of duty.
PERIOD, 100, carrier period in clk cycles (2..2^CNT_W).
DEAD_CYCLES, 4, both-gates-low cycles per leg transition (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
shoot  in  1  enable level; 1 = modulate, 0 = all gates off
angle  in  ANGLE_W  commanded electrical angle
duty  in  CNT_W  active-vector on-time per period, in cycles
g1_a  out  1  phase A high-side gate
g2_a  out  1  phase A low-side gate
g1_b  out  1  phase B high-side gate
g2_b  out  1  phase B low-side gate
g1_c  out  1  phase C high-side gate
g2_c  out  1  phase C low-side gate
sector  out  3  latched sector 0..5
period_start  out  1  one-cycle pulse at each carrier period start

Behaviour:
- Reset: state IDLE; cnt=0; all six gates=0; sector=0; period_start=0; dead-time counters=DEAD_CYCLES; latched angle/duty=0.
- States:
  - IDLE: gates 0, cnt held at 0. Sampling shoot=1 latches angle and duty, asserts period_start for that edge, and enters RUN with cnt=0.
  - RUN: cnt increments each cycle and wraps PERIOD-1→0. At each wrap, angle and duty are re-latched and period_start pulses.
  - shoot=0 in RUN: IDLE on the next edge, all gates 0 on that same edge (no dead-time wait for turn-off).
- Effective angle: angle_eff = (angle + MODULE_ID*PHASE_OFFSET) mod 2^ANGLE_W.
- Sector: sector = (angle_eff*6) >> ANGLE_W, computed with ANGLE_W+3-bit intermediate, always 0..5.
- Active vector (A,B,C) by sector: 0→100, 1→110, 2→010, 3→011, 4→001, 5→101.
- Target leg state:
  - Active vector while cnt < duty_latched, else 000 (zero vector, all low-sides).
  - duty=0 → permanent 000.
  - duty ≥ PERIOD → permanent active vector.
- Gate mapping: leg target 1 → g1=1, g2=0; target 0 → g1=0, g2=1. g1 and g2 of a leg are never both 1, in any state including reset.
- Dead time, per leg, independent:
  - On a target change, both gates go 0 on the next edge and stay 0 for exactly DEAD_CYCLES cycles; then the new gate asserts.
  - A target change during dead time restarts the counter.
  - On entering RUN from IDLE, each leg also waits DEAD_CYCLES cycles of both-low before its first gate asserts.
- Angle or duty changes mid-period have no effect until the next period_start.
- A reset asserted mid-operation overrides everything on that edge: gates 0, state IDLE.
- All outputs are registered.

Test Plan:
- Safe-off: reset, angle=12'h999, duty=60, shoot=0 for 200 cycles → all gates 0, period_start never pulses.
- Six-step decode: MODULE_ID=0, angle=12'h999, duty=60, shoot=1 → sector=3.
  - A: g2_a=1 after 4 cycles, held.
  - B/C: g1=1 from cycle 4 to cycle 59; both low cycles 60-63; g2=1 from 64 to period end.
  - period_start every 100 cycles.
- Duty extremes:
  - duty=0 → only g2_x ever high.
  - duty=200 (≥PERIOD) with angle=0 → sector 0; g1_a, g2_b, g2_c held high, no mid-period transitions.
- Phase offset: MODULE_ID=1, angle=0 → angle_eff=12'h555, sector=1, vector 110.
- Sweep: angle stepped 0..4090 by 10, one period each → sector monotonic 0→5. Check g1&g2 never both 1, and every g1/g2 handover has exactly 4 both-low cycles.
- Interrupts:
  - shoot drop at cnt=30 → all gates 0 next edge.
  - reset pulse mid-RUN → IDLE and gates 0 on that edge.
  - Re-assert shoot → fresh period_start and full dead time before the first gate asserts.
